// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI transaction arbiter.
package spi_arb_pkg;

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned CNT_W_MIN = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_t;

  // Width of the shared setup/hold down-counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned setup, input int unsigned hold);
    int unsigned m;
    m = (setup > hold) ? setup : hold;
    return (m == 0) ? CNT_W_MIN : $clog2(m + 1);
  endfunction

  // First set request searching upward from last+1, wrapping modulo n.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last,
                                               input int unsigned        n);
    logic [MAX_REQ-1:0] sh;
    int unsigned        c;
    logic [IDX_W-1:0]   idx;
    logic               found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      c  = (32'(last) + i) % n;
      sh = req >> c;
      if (!found && (i <= n) && sh[0]) begin
        idx   = IDX_W'(c);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant plus index of the winner.
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_valid
);

  logic [MAX_REQ-1:0] w_req_ext;

  always_comb begin
    w_req_ext = MAX_REQ'(i_req);
    o_index   = rr_pick(w_req_ext, i_last, NUM_REQ);
    o_valid   = |i_req;
    o_grant   = o_valid ? (NUM_REQ'(1) << o_index) : '0;
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin sharing of one SPI master with per-requester chip selects.
// Optional WAIT_DONE watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned CS_SETUP       = 2,
  parameter int unsigned CS_HOLD        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic                          err_o,
  output logic                          busy_o,
  output logic [NUM_REQ-1:0]            cs_n_o,
  output logic                          spi_start_o,
  output logic [DATA_WIDTH-1:0]         spi_data_o,
  input  logic                          spi_done_i
);

  localparam int unsigned      CNT_W      = cnt_width(CS_SETUP, CS_HOLD);
  localparam logic [CNT_W-1:0] SETUP_LOAD = (CS_SETUP == 0) ? '0 : CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = (CS_HOLD == 0) ? '0 : CNT_W'(CS_HOLD - 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || DATA_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("spi_txn_arbiter: illegal parameterisation");
  end

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]      r_sel, w_sel_nxt, r_last, w_last_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic [NUM_REQ-1:0]    r_gnt, w_gnt_nxt, r_ack, w_ack_nxt, r_cs_n, w_cs_n_nxt;
  logic                  r_err, w_err_nxt, r_busy, w_busy_nxt, r_start, w_start_nxt;
  logic [NUM_REQ-1:0]    w_arb_grant, w_sel_oh;
  logic [IDX_W-1:0]      w_arb_idx;
  logic                  w_arb_valid, w_timeout, w_done_evt;

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (req_i),
    .i_last  (r_last),
    .o_grant (w_arb_grant),
    .o_index (w_arb_idx),
    .o_valid (w_arb_valid)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                  r_to_cnt <= '0;
    else if (r_state != WAIT_DONE) r_to_cnt <= '0;
    else                          r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = (r_state == WAIT_DONE) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done_evt = (r_state == WAIT_DONE) && (spi_done_i || w_timeout);
  assign w_sel_oh   = NUM_REQ'(1) << r_sel;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: if (w_arb_valid) begin
        if (CS_SETUP == 0) w_state_nxt = START;
        else begin
          w_state_nxt = SETUP;
          w_cnt_nxt   = SETUP_LOAD;
        end
      end
      SETUP: if (r_cnt == '0) w_state_nxt = START;
             else             w_cnt_nxt   = r_cnt - 1'b1;
      START: w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (w_done_evt) begin
        if (CS_HOLD == 0) w_state_nxt = IDLE;
        else begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end
      end
      HOLD: if (r_cnt == '0) w_state_nxt = IDLE;
            else             w_cnt_nxt   = r_cnt - 1'b1;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so their registers line up with it.
  always_comb begin
    w_sel_nxt  = r_sel;
    w_data_nxt = r_data;
    w_gnt_nxt  = '0;
    if (r_state == IDLE) begin
      if (w_arb_valid) begin
        w_sel_nxt = w_arb_idx;
        w_gnt_nxt = w_arb_grant;
        for (int unsigned k = 0; k < NUM_REQ; k++)
          if (w_arb_idx == IDX_W'(k)) w_data_nxt = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (w_state_nxt != IDLE) begin
      w_gnt_nxt = w_sel_oh;
    end
    w_cs_n_nxt  = ~w_gnt_nxt;
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_start_nxt = (w_state_nxt == START);
    w_ack_nxt   = w_done_evt ? w_sel_oh : '0;
    w_err_nxt   = w_done_evt && w_timeout && !spi_done_i;
    w_last_nxt  = ((r_state != IDLE) && (w_state_nxt == IDLE)) ? r_sel : r_last;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_gnt   <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_cs_n  <= '1;
      r_start <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_gnt   <= w_gnt_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_start <= w_start_nxt;
      r_data  <= w_data_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign gnt_o       = r_gnt;
  assign ack_o       = r_ack;
  assign err_o       = r_err;
  assign busy_o      = r_busy;
  assign cs_n_o      = r_cs_n;
  assign spi_start_o = r_start;
  assign spi_data_o  = r_data;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter plus a zero setup/hold instance.
`timescale 1ns/1ps
module tb_spi_txn_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  gnt_o, ack_o, cs_n_o;
  logic        err_o, busy_o, spi_start_o;
  logic [7:0]  spi_data_o;
  logic        m_done = 1'b0;
  logic        t_done;
  logic        spi_done;
  assign spi_done = m_done | t_done;

  logic [3:0]  z_req, z_gnt, z_ack, z_cs_n;
  logic [31:0] z_data;
  logic        z_err, z_busy, z_start, z_done;
  logic [7:0]  z_spi_data;

  spi_txn_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .CS_SETUP(2), .CS_HOLD(2), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .data_i(data_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o), .cs_n_o(cs_n_o),
    .spi_start_o(spi_start_o), .spi_data_o(spi_data_o), .spi_done_i(spi_done)
  );

  spi_txn_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .CS_SETUP(0), .CS_HOLD(0), .TIMEOUT_CYCLES(64)) dut_z (
    .clk_i(clk), .reset_i(reset_i), .req_i(z_req), .data_i(z_data),
    .gnt_o(z_gnt), .ack_o(z_ack), .err_o(z_err), .busy_o(z_busy), .cs_n_o(z_cs_n),
    .spi_start_o(z_start), .spi_data_o(z_spi_data), .spi_done_i(z_done)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mdl_last = 3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [3:0] req, input int last);
    int c;
    for (int s = 1; s <= 4; s++) begin
      c = (last + s) % 4;
      if (req[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic push_exp(input int idx, input logic err);
    exp_t e;
    e.idx  = idx;
    e.data = data_i[idx*8 +: 8];
    e.err  = err;
    sb_q.push_back(e);
  endtask

  // SPI master model: done pulses m_delay cycles after the start strobe.
  int m_cnt   = 0;
  int m_delay = 3;
  bit m_en    = 1'b1;
  always @(negedge clk) begin
    m_done = 1'b0;
    if (reset_i) m_cnt = 0;
    else begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_done = 1'b1;
      end
      if (spi_start_o && m_en) m_cnt = m_delay;
    end
  end

  // Monitor: compares start and ack events against the scoreboard.
  exp_t       mon_e;
  logic [3:0] mon_oh, mon_ohn;
  logic [3:0] prev_gnt = '0;
  logic [3:0] prev_cs  = '1;
  always @(negedge clk) begin
    if (!reset_i) begin
      if (gnt_o != 4'b0 && gnt_o != prev_gnt) check_eq("cs_gap", prev_cs, 4'hF);
      if (spi_start_o) begin
        if (sb_q.size() == 0) check_eq("start_unexp", gnt_o, 4'h0);
        else begin
          mon_e   = sb_q[0];
          mon_oh  = 4'(1) << mon_e.idx;
          mon_ohn = ~mon_oh;
          check_eq("start_gnt", gnt_o, mon_oh);
          check_eq("start_cs", cs_n_o, mon_ohn);
          check_eq("start_data", spi_data_o, mon_e.data);
        end
      end
      if (ack_o != 4'b0) begin
        if (sb_q.size() == 0) check_eq("ack_unexp", ack_o, 4'h0);
        else begin
          mon_e  = sb_q.pop_front();
          mon_oh = 4'(1) << mon_e.idx;
          check_eq("ack_vec", ack_o, mon_oh);
          check_eq("ack_err", err_o, mon_e.err);
          check_eq("ack_data", spi_data_o, mon_e.data);
        end
      end
    end
    prev_gnt = gnt_o;
    prev_cs  = cs_n_o;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    req_i   = '0;
    sb_q.delete();
    mdl_last = 3;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o !== 1'b0 && n < budget) begin step(); n++; end
    check_eq("idle_reached", busy_o, 1'b0);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (spi_start_o !== 1'b1 && n < budget) begin step(); n++; end
    check_eq("start_seen", spi_start_o, 1'b1);
  endtask

  task automatic run_held(input logic [3:0] mask, input int n, input int budget);
    int got = 0;
    int guard = 0;
    int w;
    for (int i = 0; i < n; i++) begin
      w = model_pick(mask, mdl_last);
      push_exp(w, 1'b0);
      mdl_last = w;
    end
    req_i = mask;
    while (got < n && guard < budget) begin
      step();
      guard++;
      if (ack_o != 4'b0) got++;
    end
    req_i = '0;
    check_eq("held_acks", got, n);
    wait_idle(20);
  endtask

  int         n, cs_bad;
  logic [3:0] acc_ack;
  logic       acc_err, all_busy;

  initial begin
    reset_i = 1'b1; req_i = '0; data_i = 32'h44332211; t_done = 1'b0;
    z_req = '0; z_data = 32'hD4C3B2A1; z_done = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", gnt_o, 4'h0);
    check_eq("rst_cs", cs_n_o, 4'hF);
    check_eq("rst_ack", ack_o, 4'h0);
    check_eq("rst_err", err_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_start", spi_start_o, 1'b0);
    check_eq("rst_data", spi_data_o, 8'h00);
    reset_i = 1'b0;
    step();

    // Single request from requester 2, done 20 cycles after start.
    data_i[23:16] = 8'hA5;
    push_exp(2, 1'b0);
    mdl_last = 2;
    m_delay = 20;
    req_i = 4'b0100;
    step();
    check_eq("s_cs_c1", cs_n_o, 4'b1011);
    check_eq("s_gnt_c1", gnt_o, 4'b0100);
    check_eq("s_start_c1", spi_start_o, 1'b0);
    data_i[23:16] = 8'h5A;
    step();
    check_eq("s_start_c2", spi_start_o, 1'b0);
    step();
    check_eq("s_start_c3", spi_start_o, 1'b1);
    check_eq("s_data_c3", spi_data_o, 8'hA5);
    n = 0; cs_bad = 0;
    while (ack_o == 4'b0 && n < 40) begin
      step(); n++;
      if (cs_n_o !== 4'b1011) cs_bad++;
    end
    check_eq("s_ack_lat", n, 21);
    check_eq("s_cs_window", cs_bad, 0);
    check_eq("s_ack", ack_o, 4'b0100);
    req_i = '0;
    step();
    check_eq("s_ack_1cyc", ack_o, 4'h0);
    check_eq("s_gnt_hold", gnt_o, 4'b0100);
    step();
    check_eq("s_gnt_end", gnt_o, 4'h0);
    check_eq("s_cs_end", cs_n_o, 4'hF);
    check_eq("s_busy_end", busy_o, 1'b0);

    // Fairness with all requesters held.
    do_reset();
    data_i = 32'h44332211;
    m_delay = 3;
    run_held(4'hF, 8, 400);

    // Lone re-requester wins again; with a rival it yields.
    run_held(4'b0001, 2, 100);
    run_held(4'b0011, 2, 100);

    // Stray done pulses in SETUP and in the START cycle.
    m_en = 1'b0;
    push_exp(3, 1'b0);
    mdl_last = 3;
    req_i = 4'b1000;
    step();
    t_done = 1'b1;
    step();
    t_done = 1'b0;
    check_eq("stray_ack_setup", ack_o, 4'h0);
    step();
    check_eq("stray_start", spi_start_o, 1'b1);
    t_done = 1'b1;
    step();
    t_done = 1'b0;
    check_eq("stray_ack_start", ack_o, 4'h0);
    check_eq("stray_busy", busy_o, 1'b1);
    acc_ack = '0;
    repeat (4) begin step(); acc_ack |= ack_o; end
    check_eq("stray_no_ack", acc_ack, 4'h0);
    t_done = 1'b1;
    step();
    t_done = 1'b0;
    check_eq("stray_final_ack", ack_o, 4'b1000);
    req_i = '0;
    wait_idle(20);

    // Asynchronous reset in WAIT_DONE; next grant goes to requester 0.
    push_exp(1, 1'b0);
    req_i = 4'b0010;
    wait_start(10);
    repeat (3) step();
    #2 reset_i = 1'b1;
    #1;
    check_eq("arst_cs", cs_n_o, 4'hF);
    check_eq("arst_gnt", gnt_o, 4'h0);
    check_eq("arst_busy", busy_o, 1'b0);
    check_eq("arst_data", spi_data_o, 8'h00);
    req_i = '0;
    sb_q.delete();
    mdl_last = 3;
    @(negedge clk);
    reset_i = 1'b0;
    m_en = 1'b1;
    step();
    run_held(4'b0011, 1, 50);

    // Done never returned.
    m_en = 1'b0;
    req_i = 4'b0100;
`ifdef SPI_ARB_TIMEOUT_EN
    push_exp(2, 1'b1);
    mdl_last = 2;
    wait_start(10);
    n = 0;
    while (ack_o == 4'b0 && n < 100) begin step(); n++; end
    check_eq("to_latency", n, 65);
    check_eq("to_err", err_o, 1'b1);
    req_i = '0;
    wait_idle(20);
`else
    push_exp(2, 1'b0);
    wait_start(10);
    acc_err = 1'b0; acc_ack = '0; all_busy = 1'b1;
    repeat (100) begin
      step();
      acc_err |= err_o;
      acc_ack |= ack_o;
      all_busy &= busy_o;
    end
    check_eq("nto_err", acc_err, 1'b0);
    check_eq("nto_ack", acc_ack, 4'h0);
    check_eq("nto_busy", all_busy, 1'b1);
    do_reset();
`endif
    m_en = 1'b1;

    // Zero setup/hold instance; request dropped mid-transfer.
    z_req = 4'b0001;
    step();
    check_eq("z_start", z_start, 1'b1);
    check_eq("z_gnt", z_gnt, 4'b0001);
    check_eq("z_data", z_spi_data, 8'hA1);
    z_req = '0;
    step();
    check_eq("z_wait_busy", z_busy, 1'b1);
    z_done = 1'b1;
    step();
    z_done = 1'b0;
    check_eq("z_ack", z_ack, 4'b0001);
    check_eq("z_idle", z_busy, 1'b0);
    check_eq("z_cs", z_cs_n, 4'hF);
    step();
    check_eq("z_ack_1cyc", z_ack, 4'h0);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one SPI master (start/data/done handshake) between NUM_REQ requesters using round-robin arbitration.
- Generates a per-requester active-low chip select, with programmable setup and hold cycles around each transfer.
- Returns a one-cycle completion acknowledge to the requester that was granted.
- Sits between client blocks (sensor pollers, config loaders) and the single SPI master instance.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- DATA_WIDTH, 8: transfer width; must equal the SPI master's DATA_WIDTH.
- CS_SETUP, 2: cycles cs_n is low before spi_start_o; 0 is legal.
- CS_HOLD, 2: cycles cs_n stays low after done is seen; 0 is legal.
- TIMEOUT_CYCLES, 64: WAIT_DONE watchdog limit; used only with SPI_ARB_TIMEOUT_EN; must be ≥1.

Ports:
- clk_i  in  1  system clock; the single clock for the block.
- reset_i  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester request level; held until ack_o.
- data_i  in  NUM_REQ*DATA_WIDTH  flattened payloads; requester k owns slice [k*DATA_WIDTH +: DATA_WIDTH].
- gnt_o  out  NUM_REQ  one-hot grant, high from SETUP through HOLD.
- ack_o  out  NUM_REQ  one-hot, one-cycle completion pulse.
- err_o  out  1  one-cycle timeout pulse, coincident with ack_o.
- busy_o  out  1  high in any state other than IDLE.
- cs_n_o  out  NUM_REQ  active-low chip selects.
- spi_start_o  out  1  one-cycle start strobe to the SPI master.
- spi_data_o  out  DATA_WIDTH  latched payload to the SPI master.
- spi_done_i  in  1  done pulse from the SPI master.

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - state=IDLE; gnt_o=0, ack_o=0, err_o=0, busy_o=0, spi_start_o=0, spi_data_o=0; cs_n_o all ones.
  - Round-robin pointer last_q=NUM_REQ-1, so requester 0 wins first.
- All outputs are registered.
- States: IDLE -> SETUP -> START -> WAIT_DONE -> HOLD -> IDLE.
- IDLE:
  - If any req_i bit is set, pick the first set bit searching upward from last_q+1, wrapping modulo NUM_REQ.
  - Latch the winner's index (sel_q) and data_i slice into spi_data_o.
  - Next state is SETUP, or START if CS_SETUP=0.
  - gnt_o[sel] and cs_n_o[sel]=0 take effect on that next cycle.
- SETUP: stays exactly CS_SETUP cycles, counted by a down-counter of width $clog2(max(CS_SETUP,CS_HOLD)+1).
- START:
  - Exactly one cycle; spi_start_o=1.
  - spi_data_o is held stable from the IDLE latch until return to IDLE.
- WAIT_DONE:
  - Waits for spi_done_i=1.
  - On the sampling edge: ack_o[sel] pulses on the next cycle; next state is HOLD, or IDLE if CS_HOLD=0.
- HOLD: CS_HOLD cycles, then IDLE. last_q<=sel_q on exiting to IDLE; cs_n_o returns high in the IDLE cycle.
- Reference timing (CS_SETUP=2, CS_HOLD=2, req sampled at cycle 0):
  - cycles 1-2: SETUP, cs_n low.
  - cycle 3: spi_start_o high.
  - done sampled at cycle k: ack at k+1.
  - IDLE and cs_n high at k+3.
- IDLE always lasts ≥1 cycle, so back-to-back transfers are separated by at least one cs_n-high cycle.
- Boundary and simultaneous cases:
  - spi_done_i outside WAIT_DONE is ignored.
  - spi_done_i coincident with spi_start_o is ignored.
  - Dropping req_i mid-transfer does not abort; the transfer completes and ack_o still pulses.
  - A requester re-asserting req the cycle after its ack competes normally: with other requests pending it yields; if alone it wins again.
  - All requesters asserted continuously: grants cycle 0,1,2,3,0,...
  - data_i changes after the IDLE latch have no effect.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DONE.
  - After TIMEOUT_CYCLES cycles without spi_done_i, ack_o[sel] and err_o pulse together and the FSM proceeds as if done arrived (HOLD or IDLE).
  - The counter clears on every WAIT_DONE entry.
- Undefined: no counter exists, err_o is tied 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Package spi_arb_pkg holds:
  - state_t enum (IDLE, SETUP, START, WAIT_DONE, HOLD), 3-bit.
  - Function rr_pick(req, last) returning the index.
  - Localparam for the counter-width calculation.
- Sub-module spi_rr_arbiter: purely combinational, NUM_REQ parameter; inputs req and last; outputs one-hot grant, index and valid.
- Top level holds the FSM, counters and output registers.

Test Plan:
- Single request: req_i=4'b0100, data_i slice 2 = 8'hA5, done returned 20 cycles after start → cs_n_o=4'b1011 for the whole window, spi_start_o at cycle 3, spi_data_o=8'hA5, ack_o=4'b0100 one cycle, gnt_o cleared at k+3.
- Fairness: req_i=4'b1111 held for 8 transfers → grant order 0,1,2,3,0,1,2,3; each transfer preceded by ≥1 all-high cs_n cycle.
- Zero setup/hold: CS_SETUP=0, CS_HOLD=0 → spi_start_o on the cycle after req is sampled; IDLE on the cycle after done is sampled.
- Stray done: spi_done_i pulsed in SETUP and in the START cycle → no ack, FSM continues; a later done completes normally.
- Reset mid-WAIT_DONE: reset_i pulsed → cs_n_o=4'hF and gnt_o=0 asynchronously; the next grant goes to requester 0.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64): done never returned → ack_o and err_o pulse 64 cycles after WAIT_DONE entry; without the macro, err_o stays 0 and busy_o stays 1.
